// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, 2-entry prefetch FIFO
// and the IF/ID output register. Optional macro IF_BYPASS_EN writes responses straight to the output.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] addr_q;
  logic        drop_q;

  logic [1:0]  count;
  logic [31:0] head_pc, head_inst;
  logic [31:0] tail_pc, tail_inst;

  logic ack_take, accept, out_ready, pop, push, bypass;

  // Request/address depend only on state, count and rst so ack can never loop back into them.
  assign imem_req_o  = !rst && (state == WAIT || count != 2'd2);
  assign imem_addr_o = (state == WAIT) ? addr_q : fetch_pc;

  assign ack_take  = imem_req_o && imem_ack_i;
  assign accept    = ack_take && !drop_q && !redirect_i;
  assign out_ready = !redirect_i && !stall_i;
  assign pop       = out_ready && count != 2'd0;

`ifdef IF_BYPASS_EN
  assign bypass = out_ready && count == 2'd0 && accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  // Fetch FSM: a request is never withdrawn once issued; a redirect mid-request marks the
  // response for dropping instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      drop_q   <= 1'b0;
    end else begin
      if (accept)
        fetch_pc <= imem_addr_o + 32'd4;
      if (redirect_i)
        fetch_pc <= redirect_pc_i & ALIGN_MASK;
      case (state)
        IDLE: begin
          if (imem_req_o && !imem_ack_i) begin
            addr_q <= fetch_pc;
            drop_q <= redirect_i;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack_i) begin
            drop_q <= 1'b0;
            state  <= IDLE;
          end else if (redirect_i) begin
            drop_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO (head = oldest) and IF/ID output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      pc_o    <= RESET_PC;
      inst_o  <= ZERO_WORD;
      valid_o <= 1'b0;
    end else if (redirect_i) begin
      count   <= 2'd0;
      inst_o  <= ZERO_WORD;
      valid_o <= 1'b0;
    end else begin
      if (!stall_i) begin
        if (count != 2'd0) begin
          pc_o    <= head_pc;
          inst_o  <= head_inst;
          valid_o <= 1'b1;
        end else if (bypass) begin
          pc_o    <= imem_addr_o;
          inst_o  <= imem_rdata_i;
          valid_o <= 1'b1;
        end else begin
          inst_o  <= ZERO_WORD;
          valid_o <= 1'b0;
        end
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= imem_addr_o;
            head_inst <= imem_rdata_i;
          end else begin
            tail_pc   <= imem_addr_o;
            tail_inst <= imem_rdata_i;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_inst <= tail_inst;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc   <= imem_addr_o;
            head_inst <= imem_rdata_i;
          end else begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            tail_pc   <= imem_addr_o;
            tail_inst <= imem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus random traffic against a
// queue-based reference model of the fetch rules.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o, inst_o;
  logic        valid_o;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_addrq, m_opc, m_inst;
  logic        m_wait, m_drop, m_valid;
  logic [63:0] q[$];
  logic [31:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_addrq = 32'h0; m_opc = 32'h0; m_inst = 32'h0;
    m_wait = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
    q.delete();
  endtask

  task automatic model_edge(input logic r, input logic st, input logic rd,
                            input logic [31:0] rpc, input logic ak);
    logic req, ackd, acc, byp;
    logic [31:0] a;
    logic [63:0] e;
    req = !r && (m_wait || q.size() < 2);
    a   = m_wait ? m_addrq : m_pc;
    if (r) begin
      model_reset();
      return;
    end
    ackd = req && ak;
    acc  = ackd && !m_drop && !rd;
    byp  = 1'b0;
    if (rd) begin
      q.delete();
      m_valid = 1'b0;
      m_inst  = 32'h0;
      m_pc    = {rpc[31:2], 2'b00};
    end else begin
      if (!st) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_opc = e[63:32]; m_inst = e[31:0]; m_valid = 1'b1;
        end
`ifdef IF_BYPASS_EN
        else if (acc) begin
          m_opc = a; m_inst = mem_word(a); m_valid = 1'b1; byp = 1'b1;
        end
`endif
        else begin
          m_inst = 32'h0; m_valid = 1'b0;
        end
      end
      if (acc && !byp) q.push_back({a, mem_word(a)});
      if (acc) m_pc = a + 32'd4;
    end
    if (ackd) begin
      m_wait = 1'b0; m_drop = 1'b0;
    end else if (req) begin
      if (!m_wait) m_addrq = a;
      m_wait = 1'b1;
      if (rd) m_drop = 1'b1;
    end
  endtask

  // One clock cycle: drive, check the combinational request, advance model, check outputs.
  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic ak);
    logic        e_req;
    logic [31:0] e_addr;
    rst = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc; imem_ack_i = ak;
    e_addr = m_wait ? m_addrq : m_pc;
    e_req  = !r && (m_wait || q.size() < 2);
    imem_rdata_i = mem_word(e_addr);
    #2;
    chk("req", 32'(imem_req_o), 32'(e_req));
    if (e_req) chk("addr", imem_addr_o, e_addr);
    model_edge(r, st, rd, rpc, ak);
    @(posedge clk);
    #1;
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("inst", inst_o, m_inst);
    if (m_valid) chk("pc", pc_o, m_opc);
    if (valid_o) seen.push_back(pc_o);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Reset (ack during reset must be ignored), then stream from RESET_PC
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    seen.delete();
    step(0, 0, 0, 0, 1);
`ifdef IF_BYPASS_EN
    chk("first_valid_bypass", 32'(valid_o), 32'h1);
`else
    chk("first_edge_bubble", 32'(valid_o), 32'h0);
    step(0, 0, 0, 0, 1);
    chk("first_valid_edge2", 32'(valid_o), 32'h1);
`endif
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    foreach (seen[i]) chk("stream_pc", seen[i], 32'(i * 4));

    // Stall for 5 cycles with a full FIFO, then check the stream is gapless
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1);
      if (i >= 1) chk("stall_req_off", 32'(imem_req_o), 32'h0);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    for (int i = 1; i < seen.size(); i++)
      if (seen[i] != seen[i-1]) chk("stall_seq", seen[i], seen[i-1] + 32'd4);

    // Memory acks every 3rd cycle
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, (i % 3) == 2);

    // Redirect while waiting on 0x20: its data is dropped, next valid pc is 0x100
    step(0, 0, 1, 32'h20, 1);
    step(0, 0, 0, 0, 0);
    chk("wait_addr_20", imem_addr_o, 32'h20);
    seen.delete();
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("redir_first_pc", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h100);

    // Reset mid-request with a non-empty FIFO
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_inst", inst_o, 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    seen.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("midrst_restart", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h0);

    // PC wrap; low target bits must be ignored
    seen.delete();
    step(0, 0, 1, 32'hFFFF_FFFB, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("wrap_0", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap_1", (seen.size() > 1) ? seen[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_2", (seen.size() > 2) ? seen[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic r, st, rd, ak;
      logic [31:0] rpc;
      r   = ($urandom_range(99) == 0);
      st  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(19) == 0);
      ak  = ($urandom_range(9) < 6);
      rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      step(r, st, rd, rpc, ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
